// File: rtl/if2id_hs_pkg.sv
// rtl/if2id_hs_pkg.sv - shared types and helpers for the if2id_hs fetch-to-decode stage
`ifndef INST_NOP
`define INST_NOP 32'h00000013
`endif

package if2id_hs_pkg;

  typedef enum logic [1:0] {
    SRC_NONE  = 2'd0,
    SRC_SKID  = 2'd1,
    SRC_INPUT = 2'd2
  } main_src_e;

  // Occupancy from the two valid tags; skid is only ever valid behind a valid main.
  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    return {main_v & skid_v, main_v ^ skid_v};
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one valid-tagged instruction/address entry with load, clear and reset-to-NOP
module pipe_slot #(
  parameter int                INST_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = `INST_NOP
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              valid_o,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              valid_q, valid_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Loading an invalid entry empties the slot, so an empty slot always shows NOP/0.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    addr_d  = addr_q;
    if (clear_i) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
      addr_d  = '0;
    end else if (load_i) begin
      valid_d = valid_i;
      inst_d  = valid_i ? inst_i : NOP_INST;
      addr_d  = valid_i ? addr_i : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      addr_q  <= addr_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign addr_o  = addr_q;

endmodule

// File: rtl/if2id_hs.sv
// rtl/if2id_hs.sv - handshaked IF->ID stage with flush; SKID_BUF_EN adds a skid entry and registered up_ready_o
module if2id_hs
  import if2id_hs_pkg::*;
#(
  parameter int                INST_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = `INST_NOP
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [INST_W-1:0] inst_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  input  logic              flush_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic [1:0]        occ_o
);

  logic              main_valid;
  logic              skid_valid;
  logic [INST_W-1:0] skid_inst;
  logic [ADDR_W-1:0] skid_addr;
  logic              up_fire;
  logic              main_free;
  main_src_e         main_src;
  logic              main_load_valid;
  logic [INST_W-1:0] main_inst_in;
  logic [ADDR_W-1:0] main_addr_in;

`ifdef SKID_BUF_EN
  logic skid_load;
  logic skid_load_valid;

  // skid_valid is a flop, so upstream ready has no path from dn_ready_i.
  assign up_ready_o = ~skid_valid;

  // Skid captures only when main is held; it drains into main as soon as main frees.
  assign skid_load_valid = up_fire & main_valid & ~dn_ready_i;
  assign skid_load       = skid_load_valid | (skid_valid & main_free);

  pipe_slot #(
    .INST_W   (INST_W),
    .ADDR_W   (ADDR_W),
    .NOP_INST (NOP_INST)
  ) u_skid (
    .clk     (clk),
    .rstn    (rstn),
    .clear_i (flush_i),
    .load_i  (skid_load),
    .valid_i (skid_load_valid),
    .inst_i  (inst_i),
    .addr_i  (inst_addr_i),
    .valid_o (skid_valid),
    .inst_o  (skid_inst),
    .addr_o  (skid_addr)
  );
`else
  assign skid_valid = 1'b0;
  assign skid_inst  = NOP_INST;
  assign skid_addr  = '0;
  assign up_ready_o = dn_ready_i | ~main_valid;
`endif

  assign up_fire   = up_valid_i & up_ready_o;
  assign main_free = ~main_valid | dn_ready_i;

  always_comb begin
    main_src = SRC_NONE;
    if (skid_valid) begin
      main_src = SRC_SKID;
    end else if (up_fire) begin
      main_src = SRC_INPUT;
    end
  end

  always_comb begin
    main_load_valid = 1'b0;
    main_inst_in    = inst_i;
    main_addr_in    = inst_addr_i;
    unique case (main_src)
      SRC_SKID: begin
        main_load_valid = 1'b1;
        main_inst_in    = skid_inst;
        main_addr_in    = skid_addr;
      end
      SRC_INPUT: main_load_valid = 1'b1;
      default:   main_load_valid = 1'b0;
    endcase
  end

  pipe_slot #(
    .INST_W   (INST_W),
    .ADDR_W   (ADDR_W),
    .NOP_INST (NOP_INST)
  ) u_main (
    .clk     (clk),
    .rstn    (rstn),
    .clear_i (flush_i),
    .load_i  (main_free),
    .valid_i (main_load_valid),
    .inst_i  (main_inst_in),
    .addr_i  (main_addr_in),
    .valid_o (main_valid),
    .inst_o  (inst_o),
    .addr_o  (inst_addr_o)
  );

  assign dn_valid_o = main_valid;
  assign occ_o      = occ_count(main_valid, skid_valid);

endmodule

// File: tb/tb_if2id_hs.sv
// tb/tb_if2id_hs.sv - self-checking bench for if2id_hs against a queue model (either SKID_BUF_EN setting)
module tb_if2id_hs;

  localparam logic [31:0] NOP = 32'h00000013;
`ifdef SKID_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        up_valid_i = 1'b0;
  logic        up_ready_o;
  logic [31:0] inst_i = '0;
  logic [31:0] inst_addr_i = '0;
  logic        flush_i = 1'b0;
  logic        dn_valid_o;
  logic        dn_ready_i = 1'b0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic [1:0]  occ_o;

  always #5 clk = ~clk;

  if2id_hs #(
    .INST_W   (32),
    .ADDR_W   (32),
    .NOP_INST (NOP)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .up_valid_i  (up_valid_i),
    .up_ready_o  (up_ready_o),
    .inst_i      (inst_i),
    .inst_addr_i (inst_addr_i),
    .flush_i     (flush_i),
    .dn_valid_o  (dn_valid_o),
    .dn_ready_i  (dn_ready_i),
    .inst_o      (inst_o),
    .inst_addr_o (inst_addr_o),
    .occ_o       (occ_o)
  );

  ent_t src[$];
  ent_t q[$];
  ent_t deliv[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stage seen as a FIFO of capacity CAP; ready rule differs by configuration.
  function automatic bit model_ready();
    if (CAP == 2) return q.size() < 2;
    return dn_ready_i || (q.size() == 0);
  endfunction

  always @(posedge clk) begin : model_update
    bit acc;
    bit dn;
    if (!rstn || flush_i) begin
      if (rstn && q.size() > 0 && dn_ready_i) deliv.push_back(q[0]);
      q.delete();
    end else begin
      acc = up_valid_i && model_ready();
      dn  = (q.size() > 0) && dn_ready_i;
      if (dn) deliv.push_back(q.pop_front());
      if (acc) q.push_back(src.pop_front());
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] e_inst;
    logic [31:0] e_addr;
    if (chk_en) begin
      e_inst = (q.size() > 0) ? q[0].inst : NOP;
      e_addr = (q.size() > 0) ? q[0].addr : 32'h0;
      chk("dn_valid", dn_valid_o, q.size() > 0);
      chk("inst_o", inst_o, e_inst);
      chk("inst_addr_o", inst_addr_o, e_addr);
      chk("occ_o", occ_o, q.size());
      chk("up_ready_o", up_ready_o, model_ready());
    end
  end

  task automatic cyc(input bit off, input bit fl, input bit dr, input bit rs = 1'b1);
    rstn       = rs;
    flush_i    = fl;
    dn_ready_i = dr;
    up_valid_i = off && (src.size() > 0);
    if (src.size() > 0) begin
      inst_i      = src[0].inst;
      inst_addr_i = src[0].addr;
    end else begin
      inst_i      = '0;
      inst_addr_i = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_dn_valid"}, dn_valid_o, 1'b0);
    chk({tag, "_inst"}, inst_o, 32'h00000013);
    chk({tag, "_addr"}, inst_addr_o, 32'h0);
    chk({tag, "_occ"}, occ_o, 2'd0);
  endtask

  initial begin
    int base;
    bit fl;

    // Reset held two cycles with a valid offer.
    src.push_back('{32'hDEAD0000, 32'h40});
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    src.delete();
    chk_en = 1'b1;
    chk_empty("rst");
    chk("rst_up_ready", up_ready_o, 1'b1);
    cyc(0, 0, 1);

    // Streaming: 8 back-to-back, one cycle latency, no bubbles.
    for (int i = 0; i < 8; i++) src.push_back('{32'h10000000 + i, 32'(i * 4)});
    base = deliv.size();
    cyc(1, 0, 1);
    chk("stream_lat_inst", inst_o, 32'h10000000);
    chk("stream_lat_valid", dn_valid_o, 1'b1);
    for (int k = 0; k < 8; k++) cyc(1, 0, 1);
    chk("stream_count", deliv.size() - base, 8);
    for (int i = 0; i < 8; i++) begin
      chk("stream_inst", deliv[base + i].inst, 32'h10000000 + i);
      chk("stream_addr", deliv[base + i].addr, 32'(i * 4));
    end

    // Backpressure.
    src.push_back('{32'hAAAA0001, 32'h100});
    src.push_back('{32'hAAAA0002, 32'h104});
    repeat (3) cyc(1, 0, 0);
    chk("bp_occ", occ_o, CAP);
    chk("bp_up_ready", up_ready_o, 1'b0);
    chk("bp_inst", inst_o, 32'hAAAA0001);
    chk("bp_addr", inst_addr_o, 32'h100);
    base = deliv.size();
    repeat (4) cyc(1, 0, 1);
    chk("bp_count", deliv.size() - base, 2);
    chk("bp_first", deliv[base].inst, 32'hAAAA0001);
    chk("bp_second", deliv[base + 1].inst, 32'hAAAA0002);
    chk("bp_second_addr", deliv[base + 1].addr, 32'h104);

    // Flush with the stage full and an offer pending.
    src.push_back('{32'hBBBB0001, 32'h200});
    src.push_back('{32'hBBBB0002, 32'h204});
    repeat (2) cyc(1, 0, 0);
    src.push_back('{32'hBBBB0003, 32'h208});
    chk("fl_pre_occ", occ_o, CAP);
    base = deliv.size();
    cyc(1, 1, 0);
    src.delete();
    chk_empty("fl");
    repeat (3) cyc(0, 0, 1);
    chk("fl_nothing_delivered", deliv.size() - base, 0);

    // Mid-stream reset.
    src.push_back('{32'hCCCC0001, 32'h300});
    src.push_back('{32'hCCCC0002, 32'h304});
    repeat (2) cyc(1, 0, 0);
    cyc(1, 0, 0, 0);
    src.delete();
    chk_empty("mrst");
    chk("mrst_up_ready", up_ready_o, 1'b1);
    src.push_back('{32'hD0000001, 32'h400});
    base = deliv.size();
    cyc(1, 0, 1);
    chk("mrst_lat_inst", inst_o, 32'hD0000001);
    cyc(0, 0, 1);
    chk("mrst_count", deliv.size() - base, 1);
    chk("mrst_deliv", deliv[base].addr, 32'h400);

    // Random valid/ready with occasional flush.
    for (int n = 0; n < 10000; n++) begin
      while (src.size() < 3) src.push_back('{$urandom, $urandom & 32'hFFFFFFFC});
      fl = ($urandom_range(0, 99) == 0);
      cyc($urandom_range(0, 3) != 0, fl, $urandom_range(0, 2) != 0);
      if (fl) src.delete();
    end
    src.delete();
    repeat (4) cyc(0, 0, 1);
    chk("drain_empty", occ_o, 2'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
